// File: rtl/receiver_pkg.sv
// Shared definitions for the GMII receive path: state encodings, record header
// layout and framing constants (the framing constants are also used by the TX side).
package receiver_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA,
    RX_CHECK,
    RX_COMMIT,
    RX_DISCARD
  } rx_state_e;

  localparam int          HDR_WORDS     = 7;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Header word idx of a record: length, timestamp MSW first, received FCS in wire order.
  function automatic logic [15:0] hdr_word(input logic [2:0]  idx,
                                           input logic [15:0] len,
                                           input logic [63:0] ts,
                                           input logic [31:0] fcs);
    case (idx)
      3'd0:    hdr_word = len;
      3'd1:    hdr_word = ts[63:48];
      3'd2:    hdr_word = ts[47:32];
      3'd3:    hdr_word = ts[31:16];
      3'd4:    hdr_word = ts[15:0];
      3'd5:    hdr_word = fcs[31:16];
      3'd6:    hdr_word = fcs[15:0];
      default: hdr_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (reflected, init all-ones). The output is the register
// bit-reversed so a good frame run through data+FCS leaves CRC_RESIDUE.
module crc32_d8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    for (int i = 0; i < 8; i++)
      r_d = (r_d[0] ^ d[i]) ? ((r_d >> 1) ^ 32'hEDB88320) : (r_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst || init) r_q <= 32'hFFFFFFFF;
    else if (en)     r_q <= r_d;
  end

  always_comb begin
    crc = '0;
    for (int i = 0; i < 32; i++) crc[i] = r_q[31-i];
  end

endmodule

// File: rtl/receiver.sv
// GMII receive deframer: checks FCS/length/errors and writes each good frame as a
// 7-word header + data record into the 16K-word slot ring, committing on success.
module receiver
  import receiver_pkg::*;
#(
  parameter int MAX_LEN = 1514,
  parameter int MIN_LEN = 60
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic [63:0] global_counter,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [13:0] slot_rx_eth_addr,
  output logic [15:0] slot_rx_eth_data,
  output logic [1:0]  slot_rx_eth_byte_en,
  output logic        slot_rx_eth_wr_en,
  output logic [13:0] mem_wr_ptr,
  input  logic [13:0] mem_rd_ptr,
  output logic [31:0] rx_good_count,
  output logic [15:0] rx_drop_count
);

  // Byte counts include the 4 FCS bytes.
  localparam logic [15:0] MAX_CNT = 16'(MAX_LEN + 4);
  localparam logic [15:0] MIN_CNT = 16'(MIN_LEN + 4);

  rx_state_e   state_q, state_d;
  logic [13:0] wr_ptr_q, wr_ptr_d, cursor_q, cursor_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] dly_q, dly_d;
  logic [7:0]  hi_q, hi_d;
  logic [63:0] ts_q, ts_d;
  logic [2:0]  hdr_q, hdr_d;
  logic        late_q, late_d, ovf_q, ovf_d;
  logic [31:0] good_q, good_d;
  logic [15:0] drop_q, drop_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        crc_init, crc_en;
  logic [31:0] crc;
  logic [13:0] free;

  crc32_d8 u_crc (
    .clk  (gmii_rx_clk),
    .rst  (sys_rst),
    .init (crc_init),
    .en   (crc_en),
    .d    (gmii_rxd),
    .crc  (crc)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    hi_d     = hi_q;
    ts_d     = ts_q;
    hdr_d    = hdr_q;
    late_d   = late_q;
    ovf_d    = ovf_q;
    good_d   = good_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    free     = mem_rd_ptr - wr_ptr_q - 14'd1;

    case (state_q)
      RX_IDLE, RX_PREAMBLE: begin
        if (!gmii_rx_dv)                    state_d = RX_IDLE;
        else if (gmii_rxd == PREAMBLE_BYTE) state_d = RX_PREAMBLE;
        else if (gmii_rxd == SFD_BYTE) begin
          ts_d     = global_counter;
          cursor_d = wr_ptr_q + 14'(HDR_WORDS);
          cnt_d    = '0;
          ovf_d    = 1'b0;
          crc_init = 1'b1;
          state_d  = (free < 14'd8) ? RX_DISCARD : RX_DATA;
        end else                            state_d = RX_DISCARD;
      end

      RX_DATA: begin
        if (!gmii_rx_dv) begin
          state_d = RX_CHECK;
          // Odd length leaves one released byte waiting for a partner.
          if (cnt_q > 16'd4 && cnt_q[0]) begin
            if (cursor_q + 14'd1 == mem_rd_ptr) ovf_d = 1'b1;
            else begin
              wr_d     = 1'b1;
              addr_d   = cursor_q;
              wdata_d  = {hi_q, 8'h00};
              be_d     = 2'b10;
              cursor_d = cursor_q + 14'd1;
            end
          end
        end else if (gmii_rx_er) begin
          state_d = RX_DISCARD;
        end else begin
          crc_en = 1'b1;
          dly_d  = {dly_q[23:0], gmii_rxd};
          cnt_d  = cnt_q + 16'd1;
          // Once 4 bytes are held, each arrival releases the oldest; odd releases complete a pair.
          if (cnt_q >= 16'd4) begin
            if (!cnt_q[0])                         hi_d = dly_q[31:24];
            else if (cursor_q + 14'd1 == mem_rd_ptr) state_d = RX_DISCARD;
            else begin
              wr_d     = 1'b1;
              addr_d   = cursor_q;
              wdata_d  = {hi_q, dly_q[31:24]};
              be_d     = 2'b11;
              cursor_d = cursor_q + 14'd1;
            end
          end
          if (cnt_d > MAX_CNT) state_d = RX_DISCARD;
        end
      end

      RX_CHECK: begin
        late_d = gmii_rx_dv;
        if (ovf_q || cnt_q < MIN_CNT || cnt_q > MAX_CNT || crc != CRC_RESIDUE) begin
          drop_d  = drop_q + 16'd1;
          late_d  = 1'b0;
          state_d = gmii_rx_dv ? RX_DISCARD : RX_IDLE;
        end else begin
          wr_d    = 1'b1;
          addr_d  = wr_ptr_q;
          wdata_d = hdr_word(3'd0, cnt_q - 16'd4, ts_q, dly_q);
          be_d    = 2'b11;
          hdr_d   = 3'd1;
          state_d = RX_COMMIT;
        end
      end

      RX_COMMIT: begin
        late_d = late_q | gmii_rx_dv;
        if (hdr_q != 3'(HDR_WORDS)) begin
          wr_d    = 1'b1;
          addr_d  = wr_ptr_q + 14'(hdr_q);
          wdata_d = hdr_word(hdr_q, cnt_q - 16'd4, ts_q, dly_q);
          be_d    = 2'b11;
          hdr_d   = hdr_q + 3'd1;
        end else begin
          wr_ptr_d = cursor_q;
          good_d   = good_q + 32'd1;
          late_d   = 1'b0;
          // A frame that started while we were busy is discarded and counted.
          state_d  = (late_q || gmii_rx_dv) ? RX_DISCARD : RX_IDLE;
        end
      end

      RX_DISCARD: begin
        if (!gmii_rx_dv) begin
          drop_d  = drop_q + 16'd1;
          state_d = RX_IDLE;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      state_q  <= RX_IDLE;
      wr_ptr_q <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      dly_q    <= '0;
      hi_q     <= '0;
      ts_q     <= '0;
      hdr_q    <= '0;
      late_q   <= 1'b0;
      ovf_q    <= 1'b0;
      good_q   <= '0;
      drop_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      hi_q     <= hi_d;
      ts_q     <= ts_d;
      hdr_q    <= hdr_d;
      late_q   <= late_d;
      ovf_q    <= ovf_d;
      good_q   <= good_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
    end
  end

  assign slot_rx_eth_addr    = addr_q;
  assign slot_rx_eth_data    = wdata_q;
  assign slot_rx_eth_byte_en = be_q;
  assign slot_rx_eth_wr_en   = wr_q;
  assign mem_wr_ptr          = wr_ptr_q;
  assign rx_good_count       = good_q;
  assign rx_drop_count       = drop_q;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: frames are built from random or counting payloads,
// the expected record is derived from the payload and standard Ethernet CRC.
module tb_receiver;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [63:0] gc   = '0;
  logic [7:0]  rxd  = '0;
  logic        dv   = 1'b0;
  logic        er   = 1'b0;
  logic [13:0] rptr = '0;
  logic [13:0] addr, wptr;
  logic [15:0] wdata, drop;
  logic [1:0]  be;
  logic        wr;
  logic [31:0] good;

  int n_chk = 0, n_fail = 0;

  logic [7:0]  pl[$];
  logic [7:0]  fcs_b[4];
  logic [13:0] exp_wr   = '0;
  logic [31:0] exp_good = '0;
  logic [15:0] exp_drop = '0;

  logic [15:0] mem_d[16384];
  logic [1:0]  mem_be[16384];
  int          wr_cnt  = 0;
  logic        watch_f = 1'b0;
  logic        hit_f   = 1'b0;

  receiver #(.MAX_LEN(1514), .MIN_LEN(60)) dut (
    .gmii_rx_clk         (clk),
    .sys_rst             (rst),
    .global_counter      (gc),
    .gmii_rxd            (rxd),
    .gmii_rx_dv          (dv),
    .gmii_rx_er          (er),
    .slot_rx_eth_addr    (addr),
    .slot_rx_eth_data    (wdata),
    .slot_rx_eth_byte_en (be),
    .slot_rx_eth_wr_en   (wr),
    .mem_wr_ptr          (wptr),
    .mem_rd_ptr          (rptr),
    .rx_good_count       (good),
    .rx_drop_count       (drop)
  );

  always #5 clk = ~clk;

  // Memory model of the slot RAM as seen through the write port.
  always @(negedge clk) begin
    if (wr) begin
      mem_d[addr]  <= wdata;
      mem_be[addr] <= be;
      wr_cnt       <= wr_cnt + 1;
      if (watch_f && addr == 14'h000F) hit_f <= 1'b1;
    end
  end

  task automatic build(input int len, input bit counting);
    logic [31:0] c;
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(counting ? 8'(i) : 8'($urandom));
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      c = c ^ {24'h0, pl[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fcs_b[i] = c[8*i +: 8];
  endtask

  // Drives preamble, SFD, payload, FCS; returns in the middle of the first dv-low cycle.
  task automatic drive(input logic [63:0] ts, input int er_at, input int stop_at);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); dv = 1'b1; er = 1'b0; rxd = 8'h55;
    end
    @(negedge clk); rxd = 8'hD5; gc = ts;
    for (int i = 0; i < pl.size() + 4; i++) begin
      if (i == stop_at) return;
      @(negedge clk);
      rxd = (i < pl.size()) ? pl[i] : fcs_b[i - pl.size()];
      er  = (i == er_at);
    end
    @(negedge clk); dv = 1'b0; er = 1'b0; rxd = 8'h00;
  endtask

  function automatic logic [15:0] exp_word(input int i, input logic [63:0] ts);
    int k;
    k = 2 * (i - 7);
    case (i)
      0: return 16'(pl.size());
      1: return ts[63:48];
      2: return ts[47:32];
      3: return ts[31:16];
      4: return ts[15:0];
      5: return {fcs_b[0], fcs_b[1]};
      6: return {fcs_b[2], fcs_b[3]};
      default: return {pl[k], (k + 1 < pl.size()) ? pl[k+1] : 8'h00};
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({addr, wdata, be, wr} !== '0) begin
      n_fail++; $display("FAIL reset_port got %h want 0", {addr, wdata, be, wr});
    end
    n_chk++;
    if ({wptr, good, drop} !== '0) begin
      n_fail++; $display("FAIL reset_ptr_counts got %h want 0", {wptr, good, drop});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [13:0] b;
    b = exp_wr; rptr = b;
    build(60, 1'b1);
    drive(64'h1234, -1, -1);
    repeat (8) @(negedge clk);
    n_chk++;
    if (wptr !== b) begin n_fail++; $display("FAIL good_ptr_e8 got %h want %h", wptr, b); end
    @(negedge clk);
    n_chk++;
    if (wptr !== 14'(b + 37)) begin n_fail++; $display("FAIL good_ptr_e9 got %h want %h", wptr, 14'(b + 37)); end
    n_chk++;
    if (good !== exp_good + 32'd1) begin n_fail++; $display("FAIL good_count got %0d want %0d", good, exp_good + 1); end
    for (int i = 0; i < 37; i++) begin
      n_chk++;
      if (mem_d[14'(b + i)] !== exp_word(i, 64'h1234)) begin
        n_fail++; $display("FAIL good_word%0d got %h want %h", i, mem_d[14'(b + i)], exp_word(i, 64'h1234));
      end
    end
    exp_wr = 14'(b + 37); exp_good++;
  endtask

  task automatic test_odd_frame();
    logic [13:0] b;
    logic [63:0] ts;
    b = exp_wr; rptr = b; ts = {$urandom, $urandom};
    build(61, 1'b1);
    drive(ts, -1, -1);
    repeat (9) @(negedge clk);
    n_chk++;
    if (wptr !== 14'(b + 38)) begin n_fail++; $display("FAIL odd_ptr got %h want %h", wptr, 14'(b + 38)); end
    n_chk++;
    if (mem_d[14'(b + 37)] !== 16'h3C00 || mem_be[14'(b + 37)] !== 2'b10) begin
      n_fail++; $display("FAIL odd_last got %h/%b want 3c00/10", mem_d[14'(b + 37)], mem_be[14'(b + 37)]);
    end
    for (int i = 0; i < 38; i++) begin
      n_chk++;
      if (mem_d[14'(b + i)] !== exp_word(i, ts)) begin
        n_fail++; $display("FAIL odd_word%0d got %h want %h", i, mem_d[14'(b + i)], exp_word(i, ts));
      end
    end
    exp_wr = 14'(b + 38); exp_good++;
  endtask

  task automatic test_bad_fcs();
    rptr = exp_wr;
    build(60, 1'b0);
    pl[10] = pl[10] ^ 8'h04;
    drive({$urandom, $urandom}, -1, -1);
    @(negedge clk);
    n_chk++;
    if (drop !== exp_drop) begin n_fail++; $display("FAIL badfcs_drop_e1 got %0d want %0d", drop, exp_drop); end
    @(negedge clk);
    n_chk++;
    if (drop !== exp_drop + 16'd1) begin n_fail++; $display("FAIL badfcs_drop_e2 got %0d want %0d", drop, exp_drop + 1); end
    repeat (10) @(negedge clk);
    n_chk++;
    if (wptr !== exp_wr) begin n_fail++; $display("FAIL badfcs_ptr got %h want %h", wptr, exp_wr); end
    exp_drop++;
  endtask

  task automatic test_rx_er();
    int w0;
    rptr = exp_wr;
    build(100, 1'b0);
    drive({$urandom, $urandom}, 20, -1);
    w0 = wr_cnt;
    n_chk++;
    if (drop !== exp_drop) begin n_fail++; $display("FAIL rxer_drop_early got %0d want %0d", drop, exp_drop); end
    repeat (12) @(negedge clk);
    n_chk++;
    if (wr_cnt !== w0) begin n_fail++; $display("FAIL rxer_writes got %0d want %0d", wr_cnt, w0); end
    n_chk++;
    if (drop !== exp_drop + 16'd1) begin n_fail++; $display("FAIL rxer_drop got %0d want %0d", drop, exp_drop + 1); end
    n_chk++;
    if (wptr !== exp_wr || good !== exp_good) begin
      n_fail++; $display("FAIL rxer_ptr got %h/%0d want %h/%0d", wptr, good, exp_wr, exp_good);
    end
    exp_drop++;
  endtask

  task automatic test_runt_giant();
    rptr = exp_wr;
    build(59, 1'b0);
    drive({$urandom, $urandom}, -1, -1);
    repeat (12) @(negedge clk);
    n_chk++;
    if (drop !== exp_drop + 16'd1 || wptr !== exp_wr) begin
      n_fail++; $display("FAIL runt got %0d/%h want %0d/%h", drop, wptr, exp_drop + 1, exp_wr);
    end
    exp_drop++;
    build(1515, 1'b0);
    drive({$urandom, $urandom}, -1, -1);
    repeat (4) @(negedge clk);
    n_chk++;
    if (drop !== exp_drop + 16'd1 || wptr !== exp_wr || good !== exp_good) begin
      n_fail++; $display("FAIL giant got %0d/%h/%0d want %0d/%h/%0d", drop, wptr, good, exp_drop + 1, exp_wr, exp_good);
    end
    exp_drop++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ref_w[37];
    logic [63:0] ts;
    logic [13:0] b;
    b = exp_wr; rptr = b; ts = {$urandom, $urandom};
    build(60, 1'b0);
    for (int i = 0; i < 37; i++) ref_w[i] = exp_word(i, ts);
    drive(ts, -1, -1);
    repeat (2) @(negedge clk);
    build(80, 1'b0);
    drive(ts + 64'd1, -1, -1);
    repeat (12) @(negedge clk);
    n_chk++;
    if (good !== exp_good + 32'd1 || wptr !== 14'(b + 37)) begin
      n_fail++; $display("FAIL b2b_commit got %0d/%h want %0d/%h", good, wptr, exp_good + 1, 14'(b + 37));
    end
    n_chk++;
    if (drop !== exp_drop + 16'd1) begin n_fail++; $display("FAIL b2b_drop got %0d want %0d", drop, exp_drop + 1); end
    for (int i = 0; i < 37; i++) begin
      n_chk++;
      if (mem_d[14'(b + i)] !== ref_w[i]) begin
        n_fail++; $display("FAIL b2b_word%0d got %h want %h", i, mem_d[14'(b + i)], ref_w[i]);
      end
    end
    exp_wr = 14'(b + 37); exp_good++; exp_drop++;
  endtask

  task automatic test_reset_mid();
    rptr = exp_wr;
    build(100, 1'b0);
    drive({$urandom, $urandom}, -1, 30);
    rst = 1'b1; dv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({wptr, good, drop} !== '0) begin
      n_fail++; $display("FAIL reset_mid got %h/%0d/%0d want 0/0/0", wptr, good, drop);
    end
    exp_wr = '0; exp_good = '0; exp_drop = '0;
  endtask

  task automatic test_overflow();
    int rem, len, rec;
    logic [63:0] ts;
    logic [13:0] b;
    rem = (16'h3FF0 - int'(exp_wr) + 16384) % 16384;
    while (rem > 0) begin
      if (rem > 1000)     len = 1514;
      else if (rem > 600) len = 2 * (rem / 2 - 7);
      else                len = 2 * (rem - 7);
      rec = 7 + (len + 1) / 2;
      b = exp_wr; rptr = b; ts = {$urandom, $urandom};
      build(len, 1'b0);
      drive(ts, -1, -1);
      repeat (9) @(negedge clk);
      n_chk++;
      if (wptr !== 14'(b + rec) || good !== exp_good + 32'd1) begin
        n_fail++; $display("FAIL fill_commit got %h/%0d want %h/%0d", wptr, good, 14'(b + rec), exp_good + 1);
      end
      n_chk++;
      if (mem_d[b] !== 16'(len) || mem_d[14'(b + rec - 1)] !== exp_word(rec - 1, ts)) begin
        n_fail++; $display("FAIL fill_record got %h/%h want %h/%h", mem_d[b], mem_d[14'(b + rec - 1)], 16'(len), exp_word(rec - 1, ts));
      end
      exp_wr = 14'(b + rec); exp_good++; rem -= rec;
    end
    rptr = 14'h0010; watch_f = 1'b1;
    ts = {$urandom, $urandom};
    build(60, 1'b0);
    drive(ts, -1, -1);
    repeat (12) @(negedge clk);
    n_chk++;
    if (wptr !== 14'h3FF0 || drop !== exp_drop + 16'd1) begin
      n_fail++; $display("FAIL ovf_drop got %h/%0d want 3ff0/%0d", wptr, drop, exp_drop + 1);
    end
    n_chk++;
    if (hit_f !== 1'b0) begin n_fail++; $display("FAIL ovf_addr_f got %b want 0", hit_f); end
    n_chk++;
    if (mem_d[14'h000E] !== exp_word(30, ts)) begin
      n_fail++; $display("FAIL ovf_wrap_word got %h want %h", mem_d[14'h000E], exp_word(30, ts));
    end
    exp_drop++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_odd_frame();
    test_bad_fcs();
    test_rx_er();
    test_runt_giant();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

GMII receive path for the ecp3versa board: deframes packets arriving on `gmii_rxd`/`gmii_rx_dv`, checks the FCS, and stores each good frame into the RX frame slot memory. Records use the same 7-word header + data layout the transmit side consumes, so frames can be looped back or read out by the host. The memory is a 16384-word ring; a record becomes visible only when the whole frame has passed every check, at which point `mem_wr_ptr` advances past it.

## Interface
- `MAX_LEN`, default 1514: maximum accepted frame length in bytes, excluding FCS.
- `MIN_LEN`, default 60: minimum accepted frame length in bytes, excluding FCS.

Ports:
- `gmii_rx_clk` in 1: the only clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `global_counter` in 64: free-running time base.
- `gmii_rxd` in 8: GMII receive data.
- `gmii_rx_dv` in 1: GMII receive data valid.
- `gmii_rx_er` in 1: GMII receive error.
- `slot_rx_eth_addr` out 14: slot memory word address.
- `slot_rx_eth_data` out 16: write data; first byte of each pair is in [15:8].
- `slot_rx_eth_byte_en` out 2: byte enables, {[15:8],[7:0]}.
- `slot_rx_eth_wr_en` out 1: one-cycle write strobe.
- `mem_wr_ptr` out 14: committed write pointer.
- `mem_rd_ptr` in 14: consumer's read pointer.
- `rx_good_count` out 32: count of committed frames; wraps.
- `rx_drop_count` out 16: count of dropped frames; wraps.

## Operation
- **Record layout** at base address `B = mem_wr_ptr`:
  - `B+0`: frame_len, the byte count after SFD excluding the 4 FCS bytes.
  - `B+1..B+4`: timestamp[63:0], MSW first.
  - `B+5..B+6`: hash = received FCS, in wire byte order, MSW first.
  - `B+7...`: data, ceil(len/2) words.
  - Record size is 7 + ceil(len/2) words. All address arithmetic is mod 2^14.
- **Storage of data.** A 4-byte delay line holds the incoming bytes, so FCS bytes are never written as data. A byte is released when a fifth byte arrives.
  - Each released pair is written at `cursor` with byte_en 2'b11, then `cursor++`. `cursor` starts at B+7.
  - For an odd length, the leftover byte is written in RX_CHECK with byte_en 2'b10 and [7:0]=0.
- **FCS check.** CRC-32 runs over all bytes after SFD, FCS included. The frame is good iff the residue equals 32'hC704DD7B.
- **States:**
  - RX_IDLE:
    - dv & rxd==8'h55 → RX_PREAMBLE.
    - dv & rxd==8'hD5 → RX_DATA (SFD).
    - any other byte with dv → RX_DISCARD.
  - RX_PREAMBLE:
    - 8'h55 → stay.
    - 8'hD5 → RX_DATA.
    - dv=0 → RX_IDLE.
    - other byte → RX_DISCARD.
  - On SFD acceptance: latch `global_counter` as the timestamp, set `cursor=B+7`, init the CRC, zero the byte count. If free space < 8 words, go to RX_DISCARD instead.
  - RX_DATA: accept bytes while dv=1. dv=0 → RX_CHECK.
  - RX_CHECK, one cycle: write the pending odd byte, then evaluate the drop conditions. Pass → RX_COMMIT; fail → RX_IDLE with drop.
  - RX_COMMIT, 7 cycles: write header words B+0..B+6, then `mem_wr_ptr <= cursor`, `rx_good_count++`, → RX_IDLE.
  - RX_DISCARD: wait for dv=0, `rx_drop_count++`, → RX_IDLE.
- **Drop conditions.** Any of the following drops the frame:
  - rx_er asserted while dv=1 inside the frame (→ RX_DISCARD immediately);
  - FCS residue mismatch;
  - len < MIN_LEN or len > MAX_LEN (a byte count exceeding MAX_LEN+4 → RX_DISCARD immediately);
  - overflow: a data write where `cursor+1 == mem_rd_ptr` is suppressed → RX_DISCARD;
  - dv rising during RX_CHECK or RX_COMMIT: the current frame still commits, the new frame → RX_DISCARD.
- **Effect of a drop.** `mem_wr_ptr` is unchanged. Words already written beyond it are garbage and are overwritten by the next frame.
- **Occupancy invariant.** `mem_wr_ptr` never becomes equal to `mem_rd_ptr` through a commit, so equal pointers always mean empty.

## Timing
- **Reset values.** All outputs are 0; the state is RX_IDLE. Reset mid-frame abandons the frame with no drop count, and `mem_wr_ptr` returns to 0.
- **Timestamp.** Sampled in the cycle the SFD byte is present on `gmii_rxd`.
- **Write cadence.** At most one memory write per cycle. A data word is written 1 cycle after the 6th, 8th, ... byte after SFD is sampled.
- **Commit latency.** With E = the first cycle dv is sampled low:
  - E+1: RX_CHECK.
  - E+2..E+8: header writes.
  - E+9: `mem_wr_ptr` and `rx_good_count` show the new values.
- **Drop latency.** `rx_drop_count` updates in the cycle after the state leaves RX_DISCARD, or after RX_CHECK fails.
- **Pointer sampling.** `mem_rd_ptr` is sampled every cycle; it is treated as asynchronous-safe only because it is in the same clock domain (the caller is responsible for synchronisation).

## Structure
- Shared package holds:
  - the state encodings;
  - `HDR_WORDS=7`;
  - `CRC_RESIDUE=32'hC704DD7B`;
  - the preamble and SFD constants, which are also used by the TX side.
- One sub-module, `crc32_d8`: a byte-wide CRC-32 (init 32'hFFFFFFFF, reflected) with `init`, `en`, and `d[7:0]` inputs and a `crc[31:0]` output.

## Test plan
- **Good 60-byte frame.** Send 7×55, D5, 60 bytes 00..3B, then a valid FCS, with global_counter=64'h1234 at SFD.
  - Words B+0=003C, B+1..4=0000,0000,0000,1234, B+7=0001, ..., B+36=3A3B.
  - `mem_wr_ptr` = B+37 at E+9; `rx_good_count`=1.
- **Odd length, 61 bytes.** The last word is written with byte_en 2'b10 and data {3C,00}; `mem_wr_ptr` = B+38.
- **Bad FCS.** Flip one data bit → `mem_wr_ptr` unchanged; `rx_drop_count`=1.
- **rx_er mid-frame.** Assert at byte 20 → RX_DISCARD, no header writes, drop counted once after dv falls.
- **Overflow near wrap.** Set mem_rd_ptr=16'h0010, mem_wr_ptr=14'h3FF0, and send a 60-byte frame → drop; no write reaches address 0x000F.
- **Runt and giant.** A 59-byte frame and a 1515-byte frame are both dropped. A back-to-back frame whose dv rises at E+3 is dropped while the first frame still commits.
